// File: rtl/regfile_pkg.sv
// Shared register-file geometry and sizing helpers for the read and write port arbiters.
package regfile_pkg;

  localparam int REGFILE_ADDR_WIDTH = 5;
  localparam int REGFILE_DATA_WIDTH = 32;
  localparam int REGFILE_DEPTH      = 32;

  // Never returns less than 1, so a two-requester id is still a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping to 0.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for the register file's single read port: an address stage
// driving the mux select and a response stage capturing mux data, with backpressure.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         mux_address,
  input  logic [DATA_WIDTH-1:0]         mux_data,
  output logic                          rsp_valid,
  output logic [clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          rsp_ready
);

  localparam int IW = clog2(NUM_REQ);

  logic                  s1_valid;
  logic [IW-1:0]         s1_id;
  logic [IW-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         winner;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  s2_free;
  logic                  s1_free;
  logic                  accept;

  rr_arbiter #(.N(NUM_REQ), .PW(IW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_free = !s1_valid || s2_free;

  // reset_n gates the grant so requesters never see a handshake while reset is held.
  assign req_ready = gnt & {NUM_REQ{s1_free & reset_n}};
  assign accept    = |req_ready;

  always_comb begin
    winner   = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        winner   = IW'(i);
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      mux_address <= '0;
      rr_ptr      <= '0;
    end else begin
      if (s1_free) begin
        s1_valid <= accept;
        if (accept) begin
          s1_id       <= winner;
          mux_address <= sel_addr;
        end
      end
      if (accept) begin
        rr_ptr <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
      end
    end
  end

  // mux_address is held during a stall, so a late capture still reads the right register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (s2_free) begin
      rsp_valid <= s1_valid;
      rsp_id    <= s1_id;
      rsp_data  <= mux_data;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: directed scenarios plus random traffic
// checked against a capacity/round-robin reference model.
module tb_regfile_read_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  mux_address;
  logic [31:0] mux_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready;

  logic [31:0] regfile [32];
  assign mux_data = regfile[mux_address];

  regfile_read_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .mux_address (mux_address),
    .mux_data    (mux_data),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [4:0]  addr;
    logic [31:0] data;
    int          e;
  } ent_t;

  ent_t q[$];
  int   grant_log[$];
  int   mptr;
  int   acc_count;
  logic [3:0] last_acc;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_winner(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Reference: at most two reads in flight; the oldest is visible one edge after its accept edge.
  task automatic monitor();
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        mptr     = 0;
        last_acc = '0;
      end else begin
        int         w;
        logic       exp_rv;
        logic       cap;
        logic [3:0] exp_rdy;
        ent_t       ne;
        exp_rv = (q.size() > 0) && (cyc >= q[0].e + 1);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv && rsp_valid) begin
          chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
          chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
        end
        if (q.size() > 0 && q[q.size()-1].e == cyc)
          chk("mux_address", 64'(mux_address), 64'(q[q.size()-1].addr));
        cap = (q.size() < 2) || rsp_ready;
        w = model_winner(req_valid, mptr);
        exp_rdy = (cap && w >= 0) ? 4'(1 << w) : 4'b0000;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (exp_rv && rsp_valid && rsp_ready) void'(q.pop_front());
        last_acc = req_valid & req_ready;
        if (|last_acc && w >= 0) begin
          ne.id   = w;
          ne.addr = req_addr[w*5 +: 5];
          ne.data = regfile[req_addr[w*5 +: 5]];
          ne.e    = cyc + 1;
          q.push_back(ne);
          mptr = (w + 1) % 4;
          acc_count++;
          grant_log.push_back(w);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int gb, a0;
    logic [1:0]  hid;
    logic [31:0] hdata;
    n_chk = 0; n_pass = 0; mptr = 0; acc_count = 0; last_acc = '0;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    regfile[7] = 32'hDEADBEEF;
    regfile[5] = 32'hA5A50005;
    reset_n = 1'b0; req_valid = 4'b1111; req_addr = '0; rsp_ready = 1'b1;
    fork monitor(); join_none

    // Reset state
    step(); step();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_mux_address", 64'(mux_address), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    req_valid = '0;
    reset_n = 1'b1;
    step();

    // Fairness: all valid, addresses 1..4
    for (int i = 0; i < 4; i++) req_addr[i*5 +: 5] = 5'(i + 1);
    req_valid = 4'b1111;
    gb = grant_log.size();
    repeat (5) step();
    req_valid = '0;
    for (int k = 0; k < 5; k++)
      chk("rr_order", 64'((gb + k < grant_log.size()) ? grant_log[gb + k] : -1), 64'(k % 4));
    drain();

    // Single read
    req_addr[1*5 +: 5] = 5'd7;
    req_valid = 4'b0010;
    #1 chk("single_ready", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    chk("single_mux_address", 64'(mux_address), 64'(7));
    step();
    chk("single_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("single_rsp_id", 64'(rsp_id), 64'(1));
    chk("single_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));
    drain();

    // Pointer wrap: grant 2 alone, then 0 and 3 compete
    req_addr[2*5 +: 5] = 5'd9;
    req_valid = 4'b0100;
    gb = grant_log.size();
    step();
    req_addr[0*5 +: 5] = 5'd10;
    req_addr[3*5 +: 5] = 5'd11;
    req_valid = 4'b1001;
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    chk("wrap_first", 64'((gb + 1 < grant_log.size()) ? grant_log[gb + 1] : -1), 64'(3));
    chk("wrap_second", 64'((gb + 2 < grant_log.size()) ? grant_log[gb + 2] : -1), 64'(0));
    drain();

    // Backpressure: one response stalled with stage 1 empty
    rsp_ready = 1'b0;
    req_addr[0*5 +: 5] = 5'd3;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    hid = rsp_id; hdata = rsp_data;
    a0 = acc_count;
    for (int i = 0; i < 4; i++) req_addr[i*5 +: 5] = 5'($urandom_range(0, 31));
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) chk("bp_ready_low", 64'(req_ready), 64'(0));
      step();
      chk("bp_hold_valid", 64'(rsp_valid), 64'(1));
      chk("bp_hold_id", 64'(rsp_id), 64'(hid));
      chk("bp_hold_data", 64'(rsp_data), 64'(hdata));
    end
    chk("bp_extra_accepts", 64'(acc_count - a0), 64'(1));
    drain();

    // Write collision: register 5 written at the capture edge
    req_addr[1*5 +: 5] = 5'd5;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    @(posedge clk);
    regfile[5] <= 32'h1;
    #1;
    chk("collision_data", 64'(rsp_data), 64'(32'hA5A50005));
    drain();

    // Random traffic (register contents static)
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || last_acc[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_addr[i*5 +: 5] = 5'($urandom_range(0, 31));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    // Reset mid-stream with both stages full
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    step(); step();
    rsp_ready = 1'b0;
    step();
    chk("pre_reset_full", 64'(rsp_valid), 64'(1));
    #1 reset_n = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_mux_address", 64'(mux_address), 64'(0));
    step(); step();
    rsp_ready = 1'b1;
    reset_n = 1'b1;
    #1 chk("post_reset_grant", 64'(req_ready), 64'(4'b0001));
    repeat (4) step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
